alu_control_mdu: RTL and testbench
==================================

ALU_CONTROL_MDU -- requirements
Module: alu_control_mdu

Interface
REQ-001 SHALL have parameter WIDTH, default 32, datapath/operand width (>=4, even).
REQ-002 SHALL have port clk  input  1  single clock; all state changes on rising edge.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port ALUOp  input  2  main-control ALU operation class.
REQ-005 SHALL have port FuncCode  input  6  R-type funct field.
REQ-006 SHALL have port InstValid  input  1  instruction in decode this cycle is real (not bubble).
REQ-007 SHALL have port RsData  input  WIDTH  rs operand.
REQ-008 SHALL have port RtData  input  WIDTH  rt operand.
REQ-009 SHALL have port ALUControl  output  4  ALU operation select (combinational).
REQ-010 SHALL have port HiLoData  output  WIDTH  mfhi/mflo read data (combinational).
REQ-011 SHALL have port Busy  output  1  multiply/divide in progress (registered).
REQ-012 SHALL have port Stall  output  1  hold PC/decode this cycle (combinational).
REQ-013 SHALL have port Done  output  1  one-cycle pulse when HI/LO updated by mult/div.

Function
REQ-014 ALUControl SHALL be: ALUOp 00->0010; 01->0110; 10 with funct 100000->0010, 100010->0110, 100100->0000, 100101->0001, 101010->0111, 100111->1100 (NOR); every other funct and ALUOp 11->0000.
REQ-015 Issue SHALL mean InstValid=1 and ALUOp=10; MDU functs: mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011.
REQ-016 Stall SHALL be 1 iff issue of any MDU funct while Busy=1; a stalled instruction SHALL have no effect.
REQ-017 HiLoData SHALL be HI on issued mfhi, LO on issued mflo, else 0.
REQ-018 Unstalled mthi/mtlo SHALL write RsData into HI/LO at the issuing edge.
REQ-019 FSM states IDLE, MUL, DIV, FIX; IDLE->MUL on unstalled mult/multu, IDLE->DIV on div/divu; MUL/DIV->FIX after WIDTH iteration cycles; FIX->IDLE after one cycle.
REQ-020 On acceptance SHALL latch operand magnitudes (signed ops) or raw values (unsigned ops) and result-sign flags; operands SHALL NOT be re-sampled.
REQ-021 MUL SHALL be shift-add, one multiplier bit per cycle, 2*WIDTH-bit product; DIV SHALL be restoring, one quotient bit per cycle.
REQ-022 FIX SHALL apply two's-complement sign correction (product sign = sign xor; quotient sign = sign xor; remainder sign = dividend sign) and write HI/LO: mult HI=upper, LO=lower; div LO=quotient, HI=remainder.
REQ-023 Busy SHALL be 1 from the edge after acceptance for exactly WIDTH+1 cycles; Done SHALL be 1 in the single cycle after FIX (first cycle Busy=0).
REQ-024 Divide by zero SHALL complete with normal latency: LO=all ones (unsigned) or the sign-corrected result of all-ones magnitude, HI=dividend; no error flag.
REQ-025 Signed most-negative / -1 SHALL yield LO=most-negative, HI=0 (wrap, no trap).
REQ-026 An MDU issue in the same cycle Busy falls SHALL be accepted (no extra stall cycle).

Reset
REQ-027 reset SHALL asynchronously force state IDLE, HI=0, LO=0, iteration counter 0, Busy=0, Done=0, abandoning any operation.
REQ-028 After reset release, first issue SHALL behave as from power-up.

Structure
REQ-029 ALUOp codes, ALUControl codes, funct constants and FSM state enum SHALL live in shared package mips_pkg.
REQ-030 Decode SHALL remain combinational in alu_control_mdu; iterative datapath SHALL be sub-module mdu_core (FSM, counter, HI/LO).

Verification (WIDTH=32)
REQ-031 ALUOp=10 funct 100111 -> ALUControl=1100; ALUOp=01 -> 0110; funct 011000 -> 0000.
REQ-032 mult 0xFFFFFFFF x 0x00000002 -> Busy 33 cycles, Done pulse, HI=0xFFFFFFFF, LO=0xFFFFFFFE; multu same -> HI=0x00000001, LO=0xFFFFFFFE.
REQ-033 div -7 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF; divu 7/0 -> LO=0xFFFFFFFF, HI=0x00000007.
REQ-034 mflo issued 5 cycles after mult -> Stall=1 until Busy falls, then HiLoData=new LO with Stall=0.
REQ-035 reset asserted mid-divide (cycle 10) -> Busy=0 immediately, HI=LO=0, no Done; subsequent mult completes correctly.
REQ-036 mthi 0x12345678 then mfhi -> HiLoData=0x12345678; div 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS decode constants and the multiply/divide unit state encoding.
package mips_pkg;

  // Operation class from the main control unit
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;
  localparam logic [1:0] ALUOP_NONE  = 2'b11;

  // ALU operation select codes
  localparam logic [3:0] ALUCTL_AND = 4'b0000;
  localparam logic [3:0] ALUCTL_OR  = 4'b0001;
  localparam logic [3:0] ALUCTL_ADD = 4'b0010;
  localparam logic [3:0] ALUCTL_SUB = 4'b0110;
  localparam logic [3:0] ALUCTL_SLT = 4'b0111;
  localparam logic [3:0] ALUCTL_NOR = 4'b1100;

  // R-type funct fields handled by the ALU
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [5:0] F_NOR = 6'b100111;

  // R-type funct fields handled by the multiply/divide unit
  localparam logic [5:0] F_MFHI  = 6'b010000;
  localparam logic [5:0] F_MTHI  = 6'b010001;
  localparam logic [5:0] F_MFLO  = 6'b010010;
  localparam logic [5:0] F_MTLO  = 6'b010011;
  localparam logic [5:0] F_MULT  = 6'b011000;
  localparam logic [5:0] F_MULTU = 6'b011001;
  localparam logic [5:0] F_DIV   = 6'b011010;
  localparam logic [5:0] F_DIVU  = 6'b011011;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_FIX  = 2'd3
  } mdu_state_t;

  // True for any funct that touches HI/LO and therefore must wait on the MDU
  function automatic logic isMduFunct(input logic [5:0] funct);
    logic result;
    result = 1'b0;
    case (funct)
      F_MFHI, F_MTHI, F_MFLO, F_MTLO,
      F_MULT, F_MULTU, F_DIV, F_DIVU: result = 1'b1;
      default:                         result = 1'b0;
    endcase
    return result;
  endfunction

endpackage

// File: rtl/mdu_core.sv
// Iterative multiply/divide unit: shift-add multiply, restoring divide, HI/LO
// registers. Operands are reduced to magnitudes at acceptance and the sign is
// reapplied in a single fix-up cycle at the end.
module mdu_core
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_startMul,
  input  logic             i_startDiv,
  input  logic             i_opSigned,
  input  logic             i_writeHi,
  input  logic             i_writeLo,
  input  logic [WIDTH-1:0] i_rsData,
  input  logic [WIDTH-1:0] i_rtData,
  output logic [WIDTH-1:0] o_hi,
  output logic [WIDTH-1:0] o_lo,
  output logic             o_busy,
  output logic             o_done
);

  localparam int CW = $clog2(WIDTH) + 1;

  mdu_state_t         r_state;
  mdu_state_t         w_nextState;
  logic [CW-1:0]      r_count;
  logic [2*WIDTH-1:0] r_acc;
  logic [WIDTH-1:0]   r_opB;
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_negRes;
  logic               r_negRem;
  logic               r_isDiv;
  logic               r_done;

  logic               w_negA;
  logic               w_negB;
  logic [WIDTH-1:0]   w_magA;
  logic [WIDTH-1:0]   w_magB;
  logic               w_lastIter;
  logic [WIDTH-1:0]   w_addend;
  logic [WIDTH:0]     w_addSum;
  logic [2*WIDTH-1:0] w_mulNext;
  logic [WIDTH:0]     w_shifted;
  logic [WIDTH:0]     w_diff;
  logic               w_fits;
  logic [2*WIDTH-1:0] w_divNext;
  logic [2*WIDTH-1:0] w_prodFixed;
  logic [WIDTH-1:0]   w_quoFixed;
  logic [WIDTH-1:0]   w_remFixed;

  // Operand magnitudes: the most-negative value maps onto itself, which is
  // still the correct unsigned magnitude
  assign w_negA = i_opSigned & i_rsData[WIDTH-1];
  assign w_negB = i_opSigned & i_rtData[WIDTH-1];
  assign w_magA = w_negA ? -i_rsData : i_rsData;
  assign w_magB = w_negB ? -i_rtData : i_rtData;

  assign w_lastIter = (r_count == CW'(WIDTH - 1));

  // Multiply step: conditionally add multiplicand to the upper half, then
  // shift the whole product right, keeping the carry
  assign w_addend  = r_acc[0] ? r_opB : {WIDTH{1'b0}};
  assign w_addSum  = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + {1'b0, w_addend};
  assign w_mulNext = {w_addSum, r_acc[WIDTH-1:1]};

  // Divide step: upper half is the partial remainder, lower half shifts the
  // dividend out and the quotient in. A zero divisor always "fits", giving an
  // all-ones quotient and leaving the dividend in the remainder.
  assign w_shifted = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-1]};
  assign w_diff    = w_shifted - {1'b0, r_opB};
  assign w_fits    = (w_shifted >= {1'b0, r_opB});
  assign w_divNext = w_fits ? {w_diff[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b1}
                            : {w_shifted[WIDTH-1:0], r_acc[WIDTH-2:0], 1'b0};

  // Sign correction applied during the fix-up cycle
  assign w_prodFixed = r_negRes ? -r_acc : r_acc;
  assign w_quoFixed  = r_negRes ? -r_acc[WIDTH-1:0] : r_acc[WIDTH-1:0];
  assign w_remFixed  = r_negRem ? -r_acc[2*WIDTH-1:WIDTH] : r_acc[2*WIDTH-1:WIDTH];

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // Next-state logic: WIDTH iterations then one fix-up cycle
  always_comb begin
    w_nextState = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (i_startMul) begin
          w_nextState = S_MUL;
        end else if (i_startDiv) begin
          w_nextState = S_DIV;
        end
      end
      S_MUL:   if (w_lastIter) w_nextState = S_FIX;
      S_DIV:   if (w_lastIter) w_nextState = S_FIX;
      S_FIX:   w_nextState = S_IDLE;
      default: w_nextState = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, HI/LO writes and the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_count  <= '0;
      r_acc    <= '0;
      r_opB    <= '0;
      r_hi     <= '0;
      r_lo     <= '0;
      r_negRes <= 1'b0;
      r_negRem <= 1'b0;
      r_isDiv  <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_done <= (r_state == S_FIX);
      case (r_state)
        S_IDLE: begin
          if (i_startMul || i_startDiv) begin
            r_acc    <= {{WIDTH{1'b0}}, w_magA};
            r_opB    <= w_magB;
            r_negRes <= w_negA ^ w_negB;
            r_negRem <= w_negA;
            r_isDiv  <= i_startDiv;
            r_count  <= '0;
          end else begin
            if (i_writeHi) r_hi <= i_rsData;
            if (i_writeLo) r_lo <= i_rsData;
          end
        end
        S_MUL: begin
          r_acc   <= w_mulNext;
          r_count <= r_count + CW'(1);
        end
        S_DIV: begin
          r_acc   <= w_divNext;
          r_count <= r_count + CW'(1);
        end
        S_FIX: begin
          if (r_isDiv) begin
            r_hi <= w_remFixed;
            r_lo <= w_quoFixed;
          end else begin
            r_hi <= w_prodFixed[2*WIDTH-1:WIDTH];
            r_lo <= w_prodFixed[WIDTH-1:0];
          end
          r_count <= '0;
        end
        default: r_count <= '0;
      endcase
    end
  end

  assign o_hi   = r_hi;
  assign o_lo   = r_lo;
  assign o_busy = (r_state != S_IDLE);
  assign o_done = r_done;

endmodule

// File: rtl/alu_control_mdu.sv
// ALU control decode plus the issue/stall interface to the multiply/divide
// unit. Decode is purely combinational; all iterative state lives in mdu_core.
module alu_control_mdu
  import mips_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [1:0]       ALUOp,
  input  logic [5:0]       FuncCode,
  input  logic             InstValid,
  input  logic [WIDTH-1:0] RsData,
  input  logic [WIDTH-1:0] RtData,
  output logic [3:0]       ALUControl,
  output logic [WIDTH-1:0] HiLoData,
  output logic             Busy,
  output logic             Stall,
  output logic             Done
);

  logic             w_issue;
  logic             w_mduIssue;
  logic             w_accept;
  logic             w_startMul;
  logic             w_startDiv;
  logic             w_opSigned;
  logic             w_writeHi;
  logic             w_writeLo;
  logic [WIDTH-1:0] w_hi;
  logic [WIDTH-1:0] w_lo;
  logic             w_busy;

  // ALU operation select from operation class and funct
  always_comb begin
    ALUControl = ALUCTL_AND;
    case (ALUOp)
      ALUOP_ADD: ALUControl = ALUCTL_ADD;
      ALUOP_SUB: ALUControl = ALUCTL_SUB;
      ALUOP_RTYPE: begin
        case (FuncCode)
          F_ADD:   ALUControl = ALUCTL_ADD;
          F_SUB:   ALUControl = ALUCTL_SUB;
          F_AND:   ALUControl = ALUCTL_AND;
          F_OR:    ALUControl = ALUCTL_OR;
          F_SLT:   ALUControl = ALUCTL_SLT;
          F_NOR:   ALUControl = ALUCTL_NOR;
          default: ALUControl = ALUCTL_AND;
        endcase
      end
      default: ALUControl = ALUCTL_AND;
    endcase
  end

  // Any HI/LO instruction must wait while an operation is in flight; once
  // Busy drops in the same cycle the instruction goes straight through
  assign w_issue    = InstValid && (ALUOp == ALUOP_RTYPE);
  assign w_mduIssue = w_issue && isMduFunct(FuncCode);
  assign Stall      = w_mduIssue && w_busy;
  assign w_accept   = w_mduIssue && !w_busy;

  assign w_startMul = w_accept && ((FuncCode == F_MULT) || (FuncCode == F_MULTU));
  assign w_startDiv = w_accept && ((FuncCode == F_DIV)  || (FuncCode == F_DIVU));
  assign w_opSigned = (FuncCode == F_MULT) || (FuncCode == F_DIV);
  assign w_writeHi  = w_accept && (FuncCode == F_MTHI);
  assign w_writeLo  = w_accept && (FuncCode == F_MTLO);

  // HI/LO read port for mfhi/mflo
  always_comb begin
    HiLoData = '0;
    if (w_issue && (FuncCode == F_MFHI)) begin
      HiLoData = w_hi;
    end else if (w_issue && (FuncCode == F_MFLO)) begin
      HiLoData = w_lo;
    end
  end

  mdu_core #(
    .WIDTH(WIDTH)
  ) u_mduCore (
    .clk       (clk),
    .reset     (reset),
    .i_startMul(w_startMul),
    .i_startDiv(w_startDiv),
    .i_opSigned(w_opSigned),
    .i_writeHi (w_writeHi),
    .i_writeLo (w_writeLo),
    .i_rsData  (RsData),
    .i_rtData  (RtData),
    .o_hi      (w_hi),
    .o_lo      (w_lo),
    .o_busy    (w_busy),
    .o_done    (Done)
  );

  assign Busy = w_busy;

endmodule

// File: tb/tb_alu_control_mdu.sv
// Directed self-checking bench for alu_control_mdu at WIDTH=32.
module tb_alu_control_mdu;
  import mips_pkg::*;

  localparam int WIDTH = 32;

  logic             clk = 1'b0;
  logic             reset;
  logic [1:0]       ALUOp;
  logic [5:0]       FuncCode;
  logic             InstValid;
  logic [WIDTH-1:0] RsData;
  logic [WIDTH-1:0] RtData;
  logic [3:0]       ALUControl;
  logic [WIDTH-1:0] HiLoData;
  logic             Busy;
  logic             Stall;
  logic             Done;

  int checkCount = 0;
  int failCount  = 0;

  alu_control_mdu #(
    .WIDTH(WIDTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .ALUOp     (ALUOp),
    .FuncCode  (FuncCode),
    .InstValid (InstValid),
    .RsData    (RsData),
    .RtData    (RtData),
    .ALUControl(ALUControl),
    .HiLoData  (HiLoData),
    .Busy      (Busy),
    .Stall     (Stall),
    .Done      (Done)
  );

  // 10 ns clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Present one R-type instruction for exactly one rising edge
  task automatic applyStimulus(input logic [5:0] funct, input logic [31:0] rs,
                               input logic [31:0] rt);
    @(negedge clk);
    ALUOp     = ALUOP_RTYPE;
    FuncCode  = funct;
    RsData    = rs;
    RtData    = rt;
    InstValid = 1'b1;
    @(negedge clk);
    InstValid = 1'b0;
    ALUOp     = ALUOP_ADD;
    FuncCode  = 6'd0;
  endtask

  // Combinational mfhi/mflo read, removed again before the next edge
  task automatic readHiLo(input logic [5:0] funct, output logic [31:0] value);
    @(negedge clk);
    ALUOp     = ALUOP_RTYPE;
    FuncCode  = funct;
    InstValid = 1'b1;
    #1;
    value     = HiLoData;
    InstValid = 1'b0;
    ALUOp     = ALUOP_ADD;
    FuncCode  = 6'd0;
  endtask

  task automatic checkDecode(input string tag, input logic [1:0] op,
                             input logic [5:0] funct, input logic [3:0] expected);
    ALUOp    = op;
    FuncCode = funct;
    #1;
    checkOutput(tag, ALUControl, expected);
  endtask

  // Issue a mult/div, time Busy, check the Done pulse, then read HI and LO
  task automatic runMdu(input string tag, input logic [5:0] funct,
                        input logic [31:0] rs, input logic [31:0] rt,
                        input logic [31:0] expHi, input logic [31:0] expLo);
    int          busyCycles;
    logic [31:0] value;
    applyStimulus(funct, rs, rt);
    busyCycles = 0;
    while (Busy && busyCycles < 200) begin
      busyCycles++;
      @(negedge clk);
    end
    checkOutput({tag, "_busyCycles"}, 64'(busyCycles), 64'd33);
    checkOutput({tag, "_donePulse"}, 64'(Done), 64'd1);
    @(negedge clk);
    checkOutput({tag, "_doneClear"}, 64'(Done), 64'd0);
    readHiLo(F_MFHI, value);
    checkOutput({tag, "_hi"}, 64'(value), 64'(expHi));
    readHiLo(F_MFLO, value);
    checkOutput({tag, "_lo"}, 64'(value), 64'(expLo));
  endtask

  initial begin
    logic [31:0] value;
    int          stallCycles;
    bit          doneSeen;

    reset     = 1'b1;
    ALUOp     = 2'b00;
    FuncCode  = 6'd0;
    InstValid = 1'b0;
    RsData    = '0;
    RtData    = '0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset_busy", 64'(Busy), 64'd0);
    checkOutput("reset_done", 64'(Done), 64'd0);
    reset = 1'b0;
    readHiLo(F_MFHI, value);
    checkOutput("reset_hi", 64'(value), 64'd0);
    readHiLo(F_MFLO, value);
    checkOutput("reset_lo", 64'(value), 64'd0);

    // ALU control decode (InstValid low so nothing is issued)
    @(negedge clk);
    checkDecode("dec_lw",    2'b00, 6'b000000, 4'b0010);
    checkDecode("dec_beq",   2'b01, 6'b100000, 4'b0110);
    checkDecode("dec_add",   2'b10, 6'b100000, 4'b0010);
    checkDecode("dec_sub",   2'b10, 6'b100010, 4'b0110);
    checkDecode("dec_and",   2'b10, 6'b100100, 4'b0000);
    checkDecode("dec_or",    2'b10, 6'b100101, 4'b0001);
    checkDecode("dec_slt",   2'b10, 6'b101010, 4'b0111);
    checkDecode("dec_nor",   2'b10, 6'b100111, 4'b1100);
    checkDecode("dec_mult",  2'b10, 6'b011000, 4'b0000);
    checkDecode("dec_op11",  2'b11, 6'b100010, 4'b0000);
    ALUOp    = 2'b00;
    FuncCode = 6'd0;

    // Multiply and divide results, including divide by zero and overflow case
    runMdu("mult_neg1x2",  F_MULT,  32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFE);
    runMdu("multu_maxx2",  F_MULTU, 32'hFFFFFFFF, 32'h00000002, 32'h00000001, 32'hFFFFFFFE);
    runMdu("div_m7_2",     F_DIV,   32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, 32'hFFFFFFFD);
    runMdu("divu_7_0",     F_DIVU,  32'h00000007, 32'h00000000, 32'h00000007, 32'hFFFFFFFF);
    runMdu("div_minneg1",  F_DIV,   32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000);
    runMdu("divu_100_7",   F_DIVU,  32'd100,      32'd7,        32'd2,        32'd14);

    // Moves to HI and LO
    applyStimulus(F_MTHI, 32'h12345678, 32'h0);
    checkOutput("mthi_noBusy", 64'(Busy), 64'd0);
    readHiLo(F_MFHI, value);
    checkOutput("mthi_mfhi", 64'(value), 64'h12345678);
    applyStimulus(F_MTLO, 32'hCAFEF00D, 32'h0);
    readHiLo(F_MFLO, value);
    checkOutput("mtlo_mflo", 64'(value), 64'hCAFEF00D);
    readHiLo(F_MFHI, value);
    checkOutput("mtlo_hiKept", 64'(value), 64'h12345678);

    // mflo arriving mid-multiply stalls until Busy drops
    applyStimulus(F_MULT, 32'd3, 32'd5);
    ALUOp     = ALUOP_RTYPE;
    FuncCode  = F_ADD;
    InstValid = 1'b1;
    #1;
    checkOutput("stall_addNoStall", 64'(Stall), 64'd0);
    InstValid = 1'b0;
    repeat (4) @(negedge clk);
    ALUOp     = ALUOP_RTYPE;
    FuncCode  = F_MFLO;
    InstValid = 1'b1;
    #1;
    checkOutput("stall_mfloStall", 64'(Stall), 64'd1);
    stallCycles = 0;
    while (Stall && stallCycles < 100) begin
      stallCycles++;
      @(negedge clk);
      #1;
    end
    checkOutput("stall_cycles", 64'(stallCycles), 64'd29);
    checkOutput("stall_busyLow", 64'(Busy), 64'd0);
    checkOutput("stall_newLo", 64'(HiLoData), 64'd15);
    InstValid = 1'b0;
    ALUOp     = ALUOP_ADD;
    FuncCode  = 6'd0;

    // Reset mid-divide abandons the operation and clears HI/LO
    applyStimulus(F_MTHI, 32'hDEADBEEF, 32'h0);
    applyStimulus(F_DIVU, 32'd1000, 32'd3);
    repeat (9) @(negedge clk);
    checkOutput("rstMid_busyBefore", 64'(Busy), 64'd1);
    reset = 1'b1;
    #1;
    checkOutput("rstMid_busy", 64'(Busy), 64'd0);
    checkOutput("rstMid_done", 64'(Done), 64'd0);
    readHiLo(F_MFHI, value);
    checkOutput("rstMid_hi", 64'(value), 64'd0);
    readHiLo(F_MFLO, value);
    checkOutput("rstMid_lo", 64'(value), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    doneSeen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (Done || Busy) doneSeen = 1'b1;
    end
    checkOutput("rstMid_noDone", 64'(doneSeen), 64'd0);
    runMdu("postRst_mult", F_MULT, 32'd7, 32'hFFFFFFFA, 32'hFFFFFFFF, 32'hFFFFFFD6);

    $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
    $finish;
  end

endmodule
